// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - handshake and data bundle for the multi-cycle shift unit
//
// Signals:
//   in_valid/in_ready   operation handshake (A, mode, shamt qualified by in_valid)
//   A, mode, shamt      operand, operation select, shift amount
//   out_valid/out_ready result handshake (C, carry, overflow qualified by out_valid)
//   C, carry, overflow  result, last bit shifted out, ALS sign-change flag
//   busy                unit is not idle
// Modports: master drives operations and consumes results, slave is the shifter.
interface seq_shifter_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  A;
    logic [2:0]             mode;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  C;
    logic                   carry;
    logic                   overflow;
    logic                   busy;

    modport master (
        output in_valid, A, mode, shamt, out_ready,
        input  in_ready, out_valid, C, carry, overflow, busy
    );

    modport slave (
        input  in_valid, A, mode, shamt, out_ready,
        output in_ready, out_valid, C, carry, overflow, busy
    );
endinterface

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shift/rotate unit, up to STEP positions per cycle
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; discards any in-flight operation
//   bus    seq_shifter_if slave: in_valid/in_ready/A/mode/shamt in,
//          out_valid/out_ready/C/carry/overflow out, busy
// Modes: 000 LLS, 001 LRS, 010 ALS, 011 ARS, 100 RL, 101 RR, 11x PASS.
module seq_shifter #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = 5,
    parameter int STEP        = 1
) (
    input  logic          clk,
    input  logic          reset,
    seq_shifter_if.slave  bus
);
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [2:0] M_LLS = 3'b000;
    localparam logic [2:0] M_LRS = 3'b001;
    localparam logic [2:0] M_ALS = 3'b010;
    localparam logic [2:0] M_ARS = 3'b011;
    localparam logic [2:0] M_RL  = 3'b100;
    localparam logic [2:0] M_RR  = 3'b101;

    localparam logic [SHAMT_WIDTH-1:0] WIDTH_N = SHAMT_WIDTH'(DATA_WIDTH);
    localparam logic [SHAMT_WIDTH-1:0] STEP_N  = SHAMT_WIDTH'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  c_q, c_d;
    logic                   carry_q, carry_d;
    logic                   ovf_q, ovf_d;
    logic                   msb0_q, msb0_d;
    logic [2:0]             mode_q, mode_d;
    logic [SHAMT_WIDTH-1:0] rem_q, rem_d;

    logic [SHAMT_WIDTH-1:0] n_eff;
    logic [SHAMT_WIDTH-1:0] k;
    logic [DATA_WIDTH-1:0]  c_step;
    logic                   carry_step;
    logic                   ovf_step;

    // Effective position count from the incoming request. Shifts saturate at
    // the width (everything shifted out); rotates wrap, so only the low bits
    // of shamt matter.
    always_comb begin
        n_eff = '0;
        case (bus.mode)
            M_LLS, M_LRS, M_ALS, M_ARS:
                n_eff = (bus.shamt >= WIDTH_N) ? WIDTH_N : bus.shamt;
            M_RL, M_RR:
                n_eff = {1'b0, bus.shamt[SHAMT_WIDTH-2:0]};
            default:
                n_eff = '0;
        endcase
    end

    // Positions applied this cycle.
    assign k = (rem_q < STEP_N) ? rem_q : STEP_N;

    // One cycle of work: up to STEP single-position steps chained, each gated
    // by whether that position is still owed. Carry tracks the bit leaving on
    // the latest applied position; overflow accumulates sign changes in ALS.
    always_comb begin
        c_step     = c_q;
        carry_step = carry_q;
        ovf_step   = ovf_q;
        for (int i = 0; i < STEP; i++) begin
            if (SHAMT_WIDTH'(i) < rem_q) begin
                case (mode_q)
                    M_LLS, M_ALS: begin
                        carry_step = c_step[MSB];
                        c_step     = {c_step[MSB-1:0], 1'b0};
                    end
                    M_LRS: begin
                        carry_step = c_step[0];
                        c_step     = {1'b0, c_step[MSB:1]};
                    end
                    M_ARS: begin
                        carry_step = c_step[0];
                        c_step     = {c_step[MSB], c_step[MSB:1]};
                    end
                    M_RL: begin
                        carry_step = c_step[MSB];
                        c_step     = {c_step[MSB-1:0], c_step[MSB]};
                    end
                    M_RR: begin
                        carry_step = c_step[0];
                        c_step     = {c_step[0], c_step[MSB:1]};
                    end
                    default: begin
                        c_step = c_step;
                    end
                endcase
                if (mode_q == M_ALS && c_step[MSB] != msb0_q) begin
                    ovf_step = 1'b1;
                end
            end
        end
    end

    // Next state, datapath updates and handshake outputs.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        msb0_d  = msb0_q;
        mode_d  = mode_q;
        rem_d   = rem_q;

        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    c_d     = bus.A;
                    mode_d  = bus.mode;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    msb0_d  = bus.A[MSB];
                    rem_d   = n_eff;
                    state_d = (n_eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                c_d     = c_step;
                carry_d = carry_step;
                ovf_d   = ovf_step;
                rem_d   = rem_q - k;
                if (rem_q == k) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            msb0_q  <= 1'b0;
            mode_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            msb0_q  <= msb0_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.C        = c_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
endmodule
